// File: rtl/poci_master_pkg.sv
// Shared POCI definitions: bus widths, slave address map, initiator base address and state type.
package pk_poci;

  localparam int unsigned addr_width = 32;
  localparam int unsigned data_width = 32;

  localparam logic [addr_width-1:0] addr_hex  = 32'h4000_0000;
  localparam logic [addr_width-1:0] addr_ledg = 32'h4000_0010;
  localparam logic [addr_width-1:0] addr_ledr = 32'h4000_0020;

  localparam logic [addr_width-1:0] periph_base = 32'h4000_0000;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} poci_master_state_t;

endpackage

// File: rtl/if_poci.sv
// POCI bus signal bundle; pready is consulted only by initiators built with POCI_PREADY_EN.
interface if_poci;
  import pk_poci::*;

  logic [addr_width-1:0] paddr;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [data_width-1:0] pwdata;
  logic [data_width-1:0] prdata;
  logic                  pready;

  modport master (
    output paddr, pwrite, psel, penable, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata,
    output prdata, pready
  );

endinterface

// File: rtl/poci_master.sv
// POCI initiator: host request/response handshake to SETUP/ACCESS bus transfers.
// Define POCI_PREADY_EN to honour slave wait states (pready) with a TIMEOUT-cycle abort.
module poci_master
  import pk_poci::*;
#(
  parameter logic [addr_width-1:0] PERIPH_BASE = periph_base,
  parameter int unsigned           TIMEOUT     = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [addr_width-1:0] req_addr,
  input  logic [data_width-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [data_width-1:0] rsp_rdata,
  output logic                  rsp_err,
  if_poci.master                bus
);

  poci_master_state_t    state_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [data_width-1:0] rsp_rdata_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [addr_width-1:0] paddr_q;
  logic [data_width-1:0] pwdata_q;

`ifdef POCI_PREADY_EN
  localparam int unsigned TmoWidth = $clog2(TIMEOUT + 1);
  localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TIMEOUT - 1);
  logic [TmoWidth-1:0] tmo_cnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
`ifdef POCI_PREADY_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          // req_ready is always 1 here, so req_valid alone is an accept
          if (req_valid) begin
            req_ready_q <= 1'b0;
            paddr_q     <= req_addr;
            pwrite_q    <= req_write;
            pwdata_q    <= req_wdata;
            if (req_addr >= PERIPH_BASE) begin
              state_q <= SETUP;
              psel_q  <= 1'b1;
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
`ifdef POCI_PREADY_EN
          tmo_cnt_q <= '0;
`endif
        end
        ACCESS: begin
`ifdef POCI_PREADY_EN
          if (bus.pready) begin
            state_q     <= RESP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
          end else if (tmo_cnt_q == TmoLast) begin
            state_q     <= RESP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`else
          state_q     <= RESP;
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign bus.psel    = psel_q;
  assign bus.penable = penable_q;
  assign bus.pwrite  = pwrite_q;
  assign bus.paddr   = paddr_q;
  assign bus.pwdata  = pwdata_q;

endmodule
